// File: rtl/rr_arbiter_onehot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_onehot_pkg
//  Description : Shared state encodings and parameter defaults for the
//                round-robin one-hot arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package rr_arbiter_onehot_pkg;

   // Arbiter FSM: IDLE evaluates requests, GRANT holds one owner.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   localparam int c_num_req_def  = 4;
   localparam int c_idx_w_def    = 2;
   localparam int c_max_hold_def = 15;

   // Width of the hold counter: enough to represent MAX_HOLD-1 with margin.
   function automatic int hold_cnt_width(input int max_hold);
      return $clog2(max_hold) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_dec
//  Description : Binary-to-one-hot decoder with enable (2-to-4 / 3-to-8,
//                generic fallback for other sizes). All zero when en is low.
//  Revision    : 1.0  initial release
// ============================================================================
module onehot_dec #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic               en,
   input  logic [IDX_W-1:0]   sel,
   output logic [NUM_REQ-1:0] dec
);

   generate
      if (NUM_REQ == 4) begin : g_dec_2to4
         assign dec[0] = en & (sel == IDX_W'(0));
         assign dec[1] = en & (sel == IDX_W'(1));
         assign dec[2] = en & (sel == IDX_W'(2));
         assign dec[3] = en & (sel == IDX_W'(3));
      end else if (NUM_REQ == 8) begin : g_dec_3to8
         assign dec[0] = en & (sel == IDX_W'(0));
         assign dec[1] = en & (sel == IDX_W'(1));
         assign dec[2] = en & (sel == IDX_W'(2));
         assign dec[3] = en & (sel == IDX_W'(3));
         assign dec[4] = en & (sel == IDX_W'(4));
         assign dec[5] = en & (sel == IDX_W'(5));
         assign dec[6] = en & (sel == IDX_W'(6));
         assign dec[7] = en & (sel == IDX_W'(7));
      end else begin : g_dec_generic
         for (genvar i = 0; i < NUM_REQ; i++) begin : g_bit
            assign dec[i] = en & (sel == IDX_W'(i));
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_onehot_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin winner search. Requests are
//                rotated so the pointer position lands on bit 0, scanned with
//                fixed priority, and the winning position is rotated back.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   // One copy minus the top bit is enough: the highest rotation reads up to
   // bit 2*NUM_REQ-2.
   logic [2*NUM_REQ-2:0] w_req_dbl;
   logic [NUM_REQ-1:0]   w_req_rot;
   logic [IDX_W-1:0]     w_rot_idx;

   assign w_req_dbl = {req[NUM_REQ-2:0], req};
   assign w_req_rot = w_req_dbl[ptr +: NUM_REQ];

   // Fixed-priority scan of the rotated vector; lowest set bit wins.
   always_comb begin
      w_rot_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_req_rot[k]) begin
            w_rot_idx = IDX_W'(k);
         end
      end
   end

   // Un-rotate: modular add wraps naturally because NUM_REQ is a power of two.
   assign idx   = w_rot_idx + ptr;
   assign found = |req;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_onehot
//  Description : Round-robin arbiter for NUM_REQ requesters. A grant is held
//                while the owner keeps its request high, up to MAX_HOLD
//                cycles, and is presented both one-hot and as a binary index.
//                All outputs are registered; one idle cycle separates grants.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter_onehot
   import rr_arbiter_onehot_pkg::*;
#(
   parameter int NUM_REQ  = c_num_req_def,
   parameter int IDX_W    = c_idx_w_def,
   parameter int MAX_HOLD = c_max_hold_def
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               timeout
);

   localparam int                c_hc_w      = hold_cnt_width(MAX_HOLD);
   localparam logic [c_hc_w-1:0] c_hold_last = c_hc_w'(MAX_HOLD - 1);

   state_e              state_q,     state_d;
   logic [IDX_W-1:0]    ptr_q,       ptr_d;
   logic [c_hc_w-1:0]   hold_cnt_q,  hold_cnt_d;
   logic [IDX_W-1:0]    gnt_idx_q,   gnt_idx_d;
   logic                gnt_valid_q, gnt_valid_d;
   logic                timeout_q,   timeout_d;
   logic [NUM_REQ-1:0]  gnt_q,       gnt_d;

   logic                w_pick_found;
   logic [IDX_W-1:0]    w_pick_idx;
   logic                w_owner_req;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (w_pick_found),
      .idx   (w_pick_idx)
   );

   // The one-hot grant is decoded from the next index so it registers in
   // lockstep with gnt_idx/gnt_valid.
   onehot_dec #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_dec (
      .en  (gnt_valid_d),
      .sel (gnt_idx_d),
      .dec (gnt_d)
   );

   assign w_owner_req = req[gnt_idx_q];

   // Next-state logic: arbitration in IDLE, hold/release decisions in GRANT.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
            if (en && w_pick_found) begin
               state_d     = ST_GRANT;
               gnt_idx_d   = w_pick_idx;
               gnt_valid_d = 1'b1;
            end
         end
         ST_GRANT: begin
            // Owner dropping its request takes precedence over the hold cap,
            // so a simultaneous drop never reports a timeout.
            if (!w_owner_req || (hold_cnt_q == c_hold_last)) begin
               state_d     = ST_IDLE;
               gnt_idx_d   = '0;
               gnt_valid_d = 1'b0;
               hold_cnt_d  = '0;
               ptr_d       = gnt_idx_q + IDX_W'(1);
               timeout_d   = w_owner_req;
            end else begin
               hold_cnt_d  = hold_cnt_q + c_hc_w'(1);
            end
         end
         default: begin
            state_d     = ST_IDLE;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
         end
      endcase
   end

   // State, pointer, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         hold_cnt_q  <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         gnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         gnt_q       <= gnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_onehot
//  Description : Self-checking bench for rr_arbiter_onehot (NUM_REQ=4,
//                MAX_HOLD=15) with directed scenarios and a random run
//                checked against a behavioural owner/priority model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arbiter_onehot;

   localparam int NUM_REQ  = 4;
   localparam int IDX_W    = 2;
   localparam int MAX_HOLD = 15;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_valid;
   logic               timeout;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: current owner (-1 = none), cycles it has been shown,
   // the requester with top priority, and the timeout pulse.
   int m_owner = -1;
   int m_held  = 0;
   int m_prio  = 0;
   bit m_tmo   = 1'b0;

   rr_arbiter_onehot #(
      .NUM_REQ  (NUM_REQ),
      .IDX_W    (IDX_W),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [NUM_REQ-1:0] exp_gnt();
      return (m_owner < 0) ? '0 : (NUM_REQ'(1) << m_owner);
   endfunction

   // Advance model with the inputs the DUT samples, then step one clock.
   task automatic tick();
      int c;
      if (rst) begin
         m_owner = -1; m_held = 0; m_prio = 0; m_tmo = 1'b0;
      end else if (m_owner < 0) begin
         m_tmo = 1'b0;
         if (en && (req != '0)) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
               c = (m_prio + k) % NUM_REQ;
               if (req[c]) m_owner = c;
            end
            m_held = 1;
         end
      end else if (!req[m_owner]) begin
         m_prio = (m_owner + 1) % NUM_REQ; m_owner = -1; m_tmo = 1'b0;
      end else if (m_held == MAX_HOLD) begin
         m_prio = (m_owner + 1) % NUM_REQ; m_owner = -1; m_tmo = 1'b1;
      end else begin
         m_held++; m_tmo = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b1; req = '0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; req = 4'b1111;
      tick(); tick();
      n_cmp++;
      if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      n_cmp++;
      if (gnt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
      n_cmp++;
      if (gnt_idx !== 2'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", gnt_idx); end
      n_cmp++;
      if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      rst = 1'b0; req = '0;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0100;
      tick();
      n_cmp++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || gnt_valid !== 1'b1) begin
         n_err++; $display("FAIL single_grant: got gnt=%b idx=%0d v=%b want 0100/2/1", gnt, gnt_idx, gnt_valid);
      end
      req = 4'b0000;
      tick();
      n_cmp++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
         n_err++; $display("FAIL single_release: got gnt=%b v=%b want 0000/0", gnt, gnt_valid);
      end
      // Pointer now sits on 3, so requester 3 wins an all-request round.
      req = 4'b1111;
      tick();
      n_cmp++;
      if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
         n_err++; $display("FAIL single_ptr3: got gnt=%b idx=%0d want 1000/3", gnt, gnt_idx);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_round_robin();
      int exp_order [5] = '{0, 1, 2, 3, 0};
      int g = 0, held = 0, zeros = 0;
      bit prev_v = 1'b0;
      do_reset();
      req = 4'b1111;
      for (int cyc = 0; cyc < 60 && g < 5; cyc++) begin
         tick();
         if (gnt_valid) begin
            if (!prev_v) begin
               n_cmp++;
               if (int'(gnt_idx) != exp_order[g]) begin
                  n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", g, gnt_idx, exp_order[g]);
               end
               if (g > 0) begin
                  n_cmp++;
                  if (zeros != 1) begin n_err++; $display("FAIL rr_bubble[%0d]: got %0d want 1", g, zeros); end
               end
               g++; held = 0;
            end
            held++;
            zeros = 0;
            req = (held == 2) ? (4'b1111 & ~(NUM_REQ'(1) << gnt_idx)) : 4'b1111;
         end else begin
            zeros++;
            req = 4'b1111;
         end
         prev_v = gnt_valid;
      end
      n_cmp++;
      if (g != 5) begin n_err++; $display("FAIL rr_complete: got %0d grants want 5", g); end
      req = '0;
      tick(); tick();
   endtask

   task automatic test_timeout();
      int run;
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         req = (pass == 0) ? 4'b0001 : 4'b0011;
         run = 0;
         tick();
         for (int cyc = 0; cyc < 40 && gnt == 4'b0001; cyc++) begin
            run++;
            n_cmp++;
            if (timeout !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b want 0", timeout); end
            tick();
         end
         n_cmp++;
         if (run != MAX_HOLD) begin n_err++; $display("FAIL tmo_len[%0d]: got %0d want %0d", pass, run, MAX_HOLD); end
         n_cmp++;
         if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            n_err++; $display("FAIL tmo_pulse[%0d]: got gnt=%b tmo=%b want 0000/1", pass, gnt, timeout);
         end
         tick();
         n_cmp++;
         if (timeout !== 1'b0 || gnt !== ((pass == 0) ? 4'b0001 : 4'b0010)) begin
            n_err++; $display("FAIL tmo_regrant[%0d]: got gnt=%b tmo=%b", pass, gnt, timeout);
         end
      end
      req = '0;
      tick(); tick();
   endtask

   task automatic test_enable();
      do_reset();
      en = 1'b0; req = 4'b1010;
      tick(); tick(); tick();
      n_cmp++;
      if (gnt !== 4'b0000) begin n_err++; $display("FAIL en_block: got %b want 0000", gnt); end
      en = 1'b1;
      tick();
      n_cmp++;
      if (gnt !== 4'b0010) begin n_err++; $display("FAIL en_grant: got %b want 0010", gnt); end
      en = 1'b0;
      tick(); tick(); tick();
      n_cmp++;
      if (gnt !== 4'b0010) begin n_err++; $display("FAIL en_hold: got %b want 0010", gnt); end
      req = 4'b1000;
      tick();
      n_cmp++;
      if (gnt !== 4'b0000) begin n_err++; $display("FAIL en_release: got %b want 0000", gnt); end
      tick(); tick();
      n_cmp++;
      if (gnt !== 4'b0000) begin n_err++; $display("FAIL en_noregrant: got %b want 0000", gnt); end
      en = 1'b1; req = '0;
      tick();
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      req = 4'b0100;
      tick(); tick(); tick();
      n_cmp++;
      if (gnt !== 4'b0100) begin n_err++; $display("FAIL rstmid_pre: got %b want 0100", gnt); end
      rst = 1'b1;
      tick();
      n_cmp++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
         n_err++; $display("FAIL rstmid_drop: got gnt=%b v=%b want 0000/0", gnt, gnt_valid);
      end
      rst = 1'b0; req = 4'b0101;
      tick();
      n_cmp++;
      if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
         n_err++; $display("FAIL rstmid_first: got gnt=%b idx=%0d want 0001/0", gnt, gnt_idx);
      end
      req = '0;
      tick(); tick();
   endtask

   task automatic test_random();
      int wait_cnt [NUM_REQ];
      int run = 0;
      logic [NUM_REQ-1:0] applied;
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         // First half exercises en; second half keeps en high for starvation checks.
         en = (cyc < 5000) ? ($urandom_range(0, 9) < 8) : 1'b1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
         end
         applied = req;
         tick();
         n_cmp++;
         if (gnt !== exp_gnt() || gnt_valid !== (m_owner >= 0) || timeout !== m_tmo ||
             (m_owner >= 0 && int'(gnt_idx) != m_owner)) begin
            n_err++; $display("FAIL rand_model@%0d: got gnt=%b idx=%0d v=%b tmo=%b want gnt=%b tmo=%b",
                              cyc, gnt, gnt_idx, gnt_valid, timeout, exp_gnt(), m_tmo);
         end
         n_cmp++;
         if ((gnt & (gnt - 1'b1)) != '0 || gnt !== (gnt_valid ? (NUM_REQ'(1) << gnt_idx) : '0)) begin
            n_err++; $display("FAIL rand_onehot@%0d: got gnt=%b idx=%0d v=%b", cyc, gnt, gnt_idx, gnt_valid);
         end
         run = gnt_valid ? run + 1 : 0;
         n_cmp++;
         if (run > MAX_HOLD) begin n_err++; $display("FAIL rand_hold@%0d: got %0d want <=%0d", cyc, run, MAX_HOLD); end
         if (cyc >= 5000) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               wait_cnt[i] = (applied[i] && !gnt[i]) ? wait_cnt[i] + 1 : 0;
               n_cmp++;
               if (wait_cnt[i] > NUM_REQ * (MAX_HOLD + 1)) begin
                  n_err++; $display("FAIL rand_starve[%0d]@%0d: got %0d want <=%0d", i, cyc, wait_cnt[i], NUM_REQ * (MAX_HOLD + 1));
               end
            end
         end
      end
      req = '0;
      tick(); tick();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; req = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_enable();
      test_reset_mid_grant();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
